// File: rtl/sw_debounce_select_pkg.sv
// Shared definitions for the switch/button input conditioner:
// channel FSM encodings, default debounce window and select helpers.
package sw_debounce_select_pkg;

  localparam logic [1:0] ST_STABLE0 = 2'd0;
  localparam logic [1:0] ST_WAIT1   = 2'd1;
  localparam logic [1:0] ST_STABLE1 = 2'd2;
  localparam logic [1:0] ST_WAIT0   = 2'd3;

  // 10 ms at 50 MHz
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;

  localparam int unsigned SEL_W     = 3;
  localparam logic [2:0]  SEL_RESET = 3'b001;

  function automatic logic is_onehot3(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

endpackage

// File: rtl/sw_debounce_select_debounce_ch.sv
// One debounced input channel: 2-FF synchroniser, stable/wait FSM with
// window counter, and registered level plus 1-cycle rise/fall pulses.
module debounce_ch
  import sw_debounce_select_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             clean_nxt;
  logic             rise_nxt;
  logic             fall_nxt;

  // State, counter, synchroniser and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      state <= ST_STABLE0;
      cnt   <= '0;
      clean <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      state <= state_nxt;
      cnt   <= cnt_nxt;
      clean <= clean_nxt;
      rise  <= rise_nxt;
      fall  <= fall_nxt;
    end
  end

  // A level is accepted only after a full uninterrupted window; any bounce restarts it
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clean_nxt = clean;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      ST_STABLE0: begin
        if (s2) begin
          state_nxt = ST_WAIT1;
          cnt_nxt   = '0;
        end
      end
      ST_WAIT1: begin
        if (!s2) begin
          state_nxt = ST_STABLE0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_STABLE1;
          clean_nxt = 1'b1;
          rise_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_STABLE1: begin
        if (!s2) begin
          state_nxt = ST_WAIT0;
          cnt_nxt   = '0;
        end
      end
      ST_WAIT0: begin
        if (s2) begin
          state_nxt = ST_STABLE1;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_STABLE0;
          clean_nxt = 1'b0;
          fall_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = ST_STABLE0;
    endcase
  end

endmodule

// File: rtl/sw_debounce_select.sv
// Board switch/button conditioner: N_IN debounced channels with edge pulses
// and a held one-hot speed select derived from channels [2:0].
module sw_debounce_select
  import sw_debounce_select_pkg::*;
#(
  parameter int unsigned N_IN            = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IN-1:0]  raw_in,
  output logic [N_IN-1:0]  clean,
  output logic [N_IN-1:0]  rise,
  output logic [N_IN-1:0]  fall,
  output logic [SEL_W-1:0] sel_onehot
);

  if (N_IN < 3) begin : g_bad_n_in
    $error("sw_debounce_select: N_IN must be >= 3");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_window
    $error("sw_debounce_select: DEBOUNCE_CYCLES must be >= 1");
  end

  for (genvar i = 0; i < int'(N_IN); i++) begin : g_ch
    debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk  (clk),
      .reset(reset),
      .raw  (raw_in[i]),
      .clean(clean[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end

  // Ambiguous (none or several) selections keep the last valid speed
  always_ff @(posedge clk) begin
    if (!reset) begin
      sel_onehot <= SEL_RESET;
    end else if (is_onehot3(clean[2:0])) begin
      sel_onehot <= clean[2:0];
    end
  end

endmodule

// File: tb/tb_sw_debounce_select.sv
// Bench for sw_debounce_select: directed switch scenarios then random bouncing
// inputs, checked every cycle against a run-length debounce reference model.
module tb_sw_debounce_select;

  localparam int N = 4;
  localparam int D = 4;

  typedef struct packed {
    logic [3:0] clean;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [2:0] sel;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [3:0] raw_in;
  logic [3:0] clean;
  logic [3:0] rise;
  logic [3:0] fall;
  logic [2:0] sel_onehot;

  int total = 0;
  int bad   = 0;
  exp_t q[$];

  sw_debounce_select #(
    .N_IN(N),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .raw_in    (raw_in),
    .clean     (clean),
    .rise      (rise),
    .fall      (fall),
    .sel_onehot(sel_onehot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: raw reaches the decision point two samples late; a level
  // flips once it has disagreed with the clean level for D+1 consecutive samples.
  logic [3:0] m_p1, m_p2, m_clean;
  logic [2:0] m_sel;
  int         m_run [N];

  always @(posedge clk) begin : model
    exp_t       e;
    logic [2:0] old;
    e.rise = '0;
    e.fall = '0;
    if (!reset) begin
      m_p1 = '0; m_p2 = '0; m_clean = '0; m_sel = 3'b001;
      for (int c = 0; c < N; c++) m_run[c] = 0;
    end else begin
      old = m_clean[2:0];
      for (int c = 0; c < N; c++) begin
        if (m_p2[c] != m_clean[c]) m_run[c] = m_run[c] + 1;
        else m_run[c] = 0;
        if (m_run[c] == D + 1) begin
          m_clean[c] = ~m_clean[c];
          if (m_clean[c]) e.rise[c] = 1'b1;
          else e.fall[c] = 1'b1;
          m_run[c] = 0;
        end
      end
      if ($countones(old) == 1) m_sel = old;
      m_p2 = m_p1;
      m_p1 = raw_in;
    end
    e.clean = m_clean;
    e.sel   = m_sel;
    q.push_back(e);
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare on the falling edge
  always @(negedge clk) begin : monitor
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("clean", clean, e.clean);
      chk("rise", rise, e.rise);
      chk("fall", fall, e.fall);
      chk("sel_onehot", {1'b0, sel_onehot}, {1'b0, e.sel});
      chk("rise_and_fall", rise & fall, 4'h0);
    end
  end

  task automatic drive(input logic r, input logic [3:0] v);
    @(posedge clk);
    #1;
    reset  = r;
    raw_in = v;
  endtask

  task automatic hold(input int n);
    repeat (n) drive(reset, raw_in);
  endtask

  int         hold_left [N];
  logic [3:0] rv;

  initial begin
    reset  = 1'b0;
    raw_in = 4'hF;
    // reset with inputs held high, then release
    hold(2);
    drive(1'b1, 4'hF);
    hold(12);
    // all released, then clean press on channel 1
    drive(1'b1, 4'h0);
    hold(12);
    drive(1'b1, 4'h2);
    hold(12);
    // bounce on channel 0 then settle high
    drive(1'b1, 4'h3); drive(1'b1, 4'h2);
    drive(1'b1, 4'h3); drive(1'b1, 4'h2);
    drive(1'b1, 4'h3);
    hold(12);
    // channel 2 stable high, then a one-cycle low glitch
    drive(1'b1, 4'h7);
    hold(12);
    drive(1'b1, 4'h3);
    drive(1'b1, 4'h7);
    hold(12);
    // select sequence 010 -> 110 -> 100 -> 000
    drive(1'b1, 4'h2); hold(12);
    drive(1'b1, 4'h6); hold(12);
    drive(1'b1, 4'h4); hold(12);
    drive(1'b1, 4'h0); hold(12);
    // reset in the middle of channel 3's window
    drive(1'b1, 4'h8); hold(4);
    drive(1'b0, 4'h8); hold(1);
    drive(1'b1, 4'h8); hold(12);
    // random bouncing with occasional resets
    for (int c = 0; c < N; c++) hold_left[c] = 0;
    rv = raw_in;
    for (int t = 0; t < 3000; t++) begin
      for (int c = 0; c < N; c++) begin
        if (hold_left[c] == 0) begin
          rv[c] = 1'($urandom_range(0, 1));
          hold_left[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                     : int'($urandom_range(4, 14));
        end else begin
          hold_left[c]--;
        end
      end
      drive(($urandom_range(0, 399) != 0), rv);
    end
    drive(1'b1, rv);
    hold(15);
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 4'(q.size() > 1 ? 1 : 0), 4'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
